// File: rtl/spi_slave_if_if.sv
// Bus bundle between the SPI master/RAM side and the SPI slave front end.
// The "master" modport is the SPI master plus the RAM feeding tx_data/tx_valid back.
interface spi_slave_if_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  ss_n;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic [DATA_WIDTH+1:0] rx_data;
  logic                  rx_valid;

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid
  );

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI into command/data words and serialises RAM read data on MISO.
// Optional macro SPI_SLAVE_LSB_FIRST_EN: MISO shifts tx_data[0] first instead of the MSB.
module spi_slave_if #(
  parameter int DATA_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  spi_slave_if_if.slave bus
);

  localparam int RX_W  = DATA_WIDTH + 2;
  localparam int TXC_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [RX_W-2:0]       r_rx_shift;
  logic [3:0]            r_bit_cnt;
  logic                  r_word_done;
  logic                  r_rd_addr_seen;
  logic [RX_W-1:0]       r_rx_data;
  logic                  r_rx_valid;
  logic                  r_tx_busy;
  logic                  r_tx_done;
  logic [TXC_W-1:0]      r_tx_cnt;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic                  r_miso;

  logic                  w_tx_load;
  logic                  w_tx_first;
  logic [DATA_WIDTH-1:0] w_tx_load_shift;
  logic                  w_tx_next;
  logic [DATA_WIDTH-1:0] w_tx_shifted;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_tx_first      = bus.tx_data[0];
  assign w_tx_load_shift = bus.tx_data >> 1;
  assign w_tx_next       = r_tx_shift[0];
  assign w_tx_shifted    = r_tx_shift >> 1;
`else
  assign w_tx_first      = bus.tx_data[DATA_WIDTH-1];
  assign w_tx_load_shift = bus.tx_data << 1;
  assign w_tx_next       = r_tx_shift[DATA_WIDTH-1];
  assign w_tx_shifted    = r_tx_shift << 1;
`endif

  // tx_valid is only honoured once the read-data word is in and before a transfer has run
  assign w_tx_load = (r_state == READ_DATA) && r_word_done && !r_tx_busy && !r_tx_done
                     && bus.tx_valid;

  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    if (bus.ss_n) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next_state = CHK_CMD;
        CHK_CMD: begin
          if (!bus.mosi)          w_next_state = WRITE;
          else if (r_rd_addr_seen) w_next_state = READ_DATA;
          else                     w_next_state = READ_ADD;
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_shift     <= '0;
      r_bit_cnt      <= '0;
      r_word_done    <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_tx_busy      <= 1'b0;
      r_tx_done      <= 1'b0;
      r_tx_cnt       <= '0;
      r_tx_shift     <= '0;
      r_miso         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (bus.ss_n) begin
        r_bit_cnt   <= '0;
        r_word_done <= 1'b0;
        r_tx_busy   <= 1'b0;
        r_tx_done   <= 1'b0;
        r_miso      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: r_bit_cnt <= '0;
          CHK_CMD: begin
            r_rx_shift <= {r_rx_shift[RX_W-3:0], bus.mosi};
            r_bit_cnt  <= 4'd1;
          end
          default: begin
            if (!r_word_done) begin
              r_rx_shift <= {r_rx_shift[RX_W-3:0], bus.mosi};
              r_bit_cnt  <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd9) begin
                r_rx_data   <= {r_rx_shift, bus.mosi};
                r_rx_valid  <= 1'b1;
                r_word_done <= 1'b1;
                if (r_state == READ_ADD) r_rd_addr_seen <= 1'b1;
              end
            end
          end
        endcase

        if (w_tx_load) begin
          r_miso     <= w_tx_first;
          r_tx_shift <= w_tx_load_shift;
          r_tx_cnt   <= TXC_W'(DATA_WIDTH - 1);
          if (DATA_WIDTH == 1) begin
            r_tx_done      <= 1'b1;
            r_rd_addr_seen <= 1'b0;
          end else begin
            r_tx_busy <= 1'b1;
          end
        end else if (r_tx_busy) begin
          r_miso     <= w_tx_next;
          r_tx_shift <= w_tx_shifted;
          r_tx_cnt   <= r_tx_cnt - TXC_W'(1);
          // the flag clears as the last bit goes out, so an ss_n rise right after keeps it clear
          if (r_tx_cnt == TXC_W'(1)) begin
            r_tx_busy      <= 1'b0;
            r_tx_done      <= 1'b1;
            r_rd_addr_seen <= 1'b0;
          end
        end else begin
          r_miso <= 1'b0;
        end
      end
    end
  end

  assign bus.miso     = r_miso;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Serial front end of the SPI-RAM subsystem: converts an SPI master's MOSI bit stream into 10-bit command/data words for the single-port RAM, and serialises RAM read data back out on MISO. It sits directly upstream of the RAM (drives `rx_data`/`rx_valid`) and consumes the RAM's `dout`/`tx_valid` as `tx_data`/`tx_valid`. The block has one clock domain: `clk` is the SPI serial clock, and all sampling happens on its rising edge.

## Interface
- `DATA_WIDTH`, default 8: RAM data and address width. The RX word is `DATA_WIDTH+2` bits.
- `clk`  in  1  clock; MOSI is sampled and MISO is updated on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ss_n`  in  1  active-low slave select.
- `mosi`  in  1  serial input, MSB first.
- `tx_data`  in  DATA_WIDTH  read data from the RAM.
- `tx_valid`  in  1  `tx_data` is valid (one-cycle pulse from the RAM).
- `miso`  out  1  serial output.
- `rx_data`  out  DATA_WIDTH+2  word to the RAM. `[9:8]` is the command, `[7:0]` is the address or data.
- `rx_valid`  out  1  one-cycle strobe qualifying `rx_data`.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: `ss_n`=0 at an edge -> CHK_CMD. `mosi` is ignored on that edge.
- CHK_CMD, at the next edge: `mosi` is captured as bit 9, then:
  - 0 -> WRITE;
  - 1 with `rd_addr_seen`=0 -> READ_ADD;
  - 1 with `rd_addr_seen`=1 -> READ_DATA.
- WRITE, READ_ADD and READ_DATA shift in bits 8..0 on the next 9 edges, MSB first.
- On the 10th captured bit:
  - the full word is registered into `rx_data`;
  - `rx_valid`=1 for exactly one cycle;
  - the bits are forwarded unmodified, with no command re-encoding.
- Words after the first in one select window are not captured. WRITE and READ_ADD hold state until `ss_n`=1.
- `rd_addr_seen` (internal flag):
  - set when a READ_ADD word completes;
  - cleared when a READ_DATA MISO transfer completes, or on `rst`.
- READ_DATA, after `rx_valid`:
  - waits for `tx_valid`=1;
  - latches `tx_data` into the TX shift register;
  - shifts out DATA_WIDTH bits on `miso`, one per edge;
  - then holds `miso`=0 until `ss_n`=1.
- `tx_valid` is ignored outside the READ_DATA wait phase. If it never arrives, `miso` stays 0.
- `ss_n`=1 at any edge, in any state, has these effects:
  - state -> IDLE, bit counter cleared, no `rx_valid` for a partial word, `miso`=0;
  - `rd_addr_seen` unchanged, except that a completed READ_DATA transfer has already cleared it.
- Reset values: state IDLE, `miso`=0, `rx_data`=0, `rx_valid`=0, `rd_addr_seen`=0. `rst` overrides `ss_n` and all other inputs.

## Timing
- Edge numbering: E0 is the first edge with `ss_n`=0. E1..E10 capture bits 9..0.
- `rx_valid` is high in the cycle after E10 and low after E11.
- The RAM raises `tx_valid` after E11. The slave samples it at E12 and drives the first MISO bit after E12.
- The last MISO bit is driven after E19, or later if `tx_valid` is delayed.
- Back-to-back transactions need at least one edge with `ss_n`=1 between them.
- `mosi` must be stable around the rising edge. Nothing is sampled on the falling edge.

## Configuration
- `SPI_SLAVE_LSB_FIRST_EN`:
  - defined: MISO shifts `tx_data[0]` first;
  - undefined (default): MISO shifts `tx_data[7]` first.
- MOSI order is always MSB first.

## Test plan
- Write address: `ss_n`=0, MOSI 00_0010_1010 -> `rx_data`=0x02A, with `rx_valid` high for exactly one cycle after E10.
- Write data: MOSI 01_0101_1100 -> `rx_data`=0x15C, one pulse.
- Read address, then read data:
  - stimulus: 10_0010_1010, then 11_0000_0000, with the RAM model returning `tx_valid` and `tx_data`=0x5C;
  - response: `rx_data`=0x22A then 0x300, and `miso`=0,1,0,1,1,1,0,0 after E12..E19;
  - repeated with the macro defined: LSB-first order.
- Abort: `ss_n` rises after 5 bits -> no `rx_valid`, state IDLE. A following full write-address word then decodes correctly.
- Flag: a read command with `rd_addr_seen`=0 goes to READ_ADD. A second read command after a completed READ_DATA also goes to READ_ADD.
- Reset: `rst` asserted during the MISO shift -> at the next edge `miso`=0, `rx_valid`=0, state IDLE, `rd_addr_seen`=0.
